// File: rtl/encode_out.sv
// LZS encoder back end: packs 1..13-bit codes MSB-first into 64-bit FIFO words.
// Optional build macro ENCODE_OUT_BSWAP_EN byte-reverses fo_data for little-endian hosts.
module encode_out #(
  parameter int IN_WIDTH       = 13,
  parameter int NEED_STR_WIDTH = 4,
  parameter int OUT_WIDTH      = 64,
  parameter int LZF_WIDTH      = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic [IN_WIDTH-1:0]       code_data,
  input  logic [NEED_STR_WIDTH-1:0] code_width,
  input  logic                      code_valid,
  input  logic                      code_last,
  output logic                      code_ack,
  input  logic                      fo_full,
  output logic [OUT_WIDTH-1:0]      fo_data,
  output logic                      fo_valid,
  output logic                      fo_last,
  output logic [LZF_WIDTH-1:0]      enc_cnt,
  output logic                      enc_done
);

  localparam int FILL_W = $clog2(OUT_WIDTH);
  localparam int SUM_W  = FILL_W + 1;
  localparam int SH_W   = FILL_W + 2;
  localparam int WIDE_W = 2 * OUT_WIDTH;

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, DONE = 2'd2} state_t;

  state_t                    state_r, state_nx_s;
  logic [OUT_WIDTH-1:0]      acc_r, acc_nx_s;
  logic [FILL_W-1:0]         fill_r, fill_nx_s;
  logic [LZF_WIDTH-1:0]      enc_cnt_r, cnt_nx_s;
  logic [OUT_WIDTH-1:0]      fo_data_r, data_nx_s;
  logic                      fo_valid_r, fo_last_r, enc_done_r;
  logic                      wr_s, wr_last_s, done_s, code_ack_s;
  logic                      width_ok_s, word_done_s;
  logic [NEED_STR_WIDTH-1:0] w_s;
  logic [IN_WIDTH-1:0]       code_m_s;
  logic [SUM_W-1:0]          sum_s;
  logic [SH_W-1:0]           shamt_s;
  logic [WIDE_W-1:0]         wide_s;

  function automatic logic [OUT_WIDTH-1:0] out_order(input logic [OUT_WIDTH-1:0] word);
    logic [OUT_WIDTH-1:0] res;
`ifdef ENCODE_OUT_BSWAP_EN
    for (int i = 0; i < OUT_WIDTH / 8; i++) begin
      res[8*i +: 8] = word[OUT_WIDTH-8-8*i +: 8];
    end
`else
    res = word;
`endif
    return res;
  endfunction

  // Illegal widths are acked but treated as zero-length codes.
  assign width_ok_s  = (code_width >= NEED_STR_WIDTH'(1)) && (code_width <= NEED_STR_WIDTH'(IN_WIDTH));
  assign w_s         = width_ok_s ? code_width : NEED_STR_WIDTH'(0);
  assign code_m_s    = code_data & ((IN_WIDTH'(1'b1) << w_s) - IN_WIDTH'(1'b1));
  assign sum_s       = SUM_W'(fill_r) + SUM_W'(w_s);
  assign word_done_s = sum_s >= SUM_W'(OUT_WIDTH);
  // The upper half of wide_s is the (possibly completed) word, the lower half the carry.
  assign shamt_s     = SH_W'(WIDE_W) - SH_W'(sum_s);
  assign wide_s      = {acc_r, OUT_WIDTH'(1'b0)} | (WIDE_W'(code_m_s) << shamt_s);
  assign code_ack_s  = rst & ce & code_valid & ~fo_full & (state_r == RUN);

  // Next-state, accumulator and write-strobe decode.
  always_comb begin
    state_nx_s = state_r;
    acc_nx_s   = acc_r;
    fill_nx_s  = fill_r;
    cnt_nx_s   = enc_cnt_r;
    data_nx_s  = fo_data_r;
    wr_s       = 1'b0;
    wr_last_s  = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (code_ack_s) begin
          if (word_done_s) begin
            wr_s      = 1'b1;
            data_nx_s = out_order(wide_s[WIDE_W-1:OUT_WIDTH]);
            acc_nx_s  = wide_s[OUT_WIDTH-1:0];
            fill_nx_s = FILL_W'(sum_s - SUM_W'(OUT_WIDTH));
            cnt_nx_s  = enc_cnt_r + LZF_WIDTH'(1'b1);
          end else begin
            acc_nx_s  = wide_s[WIDE_W-1:OUT_WIDTH];
            fill_nx_s = FILL_W'(sum_s);
          end
          if (code_last) begin
            if (fill_nx_s == FILL_W'(0)) begin
              state_nx_s = DONE;
              wr_last_s  = word_done_s;
            end else begin
              state_nx_s = FLUSH;
            end
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = RUN;
        end
      end
      FLUSH: begin
        if (ce && !fo_full) begin
          wr_s       = 1'b1;
          wr_last_s  = 1'b1;
          data_nx_s  = out_order(acc_r);
          cnt_nx_s   = enc_cnt_r + LZF_WIDTH'(1'b1);
          state_nx_s = DONE;
        end else begin
          state_nx_s = FLUSH;
        end
      end
      DONE: begin
        if (ce) begin
          done_s     = 1'b1;
          acc_nx_s   = OUT_WIDTH'(1'b0);
          fill_nx_s  = FILL_W'(0);
          cnt_nx_s   = LZF_WIDTH'(0);
          state_nx_s = RUN;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = RUN;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath and output registers; the write strobes self-clear every clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r      <= OUT_WIDTH'(1'b0);
      fill_r     <= FILL_W'(0);
      enc_cnt_r  <= LZF_WIDTH'(0);
      fo_data_r  <= OUT_WIDTH'(1'b0);
      fo_valid_r <= 1'b0;
      fo_last_r  <= 1'b0;
      enc_done_r <= 1'b0;
    end else begin
      acc_r      <= acc_nx_s;
      fill_r     <= fill_nx_s;
      enc_cnt_r  <= cnt_nx_s;
      fo_data_r  <= data_nx_s;
      fo_valid_r <= wr_s;
      fo_last_r  <= wr_last_s;
      enc_done_r <= done_s;
    end
  end

  assign code_ack = code_ack_s;
  assign fo_data  = fo_data_r;
  assign fo_valid = fo_valid_r;
  assign fo_last  = fo_last_r;
  assign enc_cnt  = enc_cnt_r;
  assign enc_done = enc_done_r;

endmodule

// File: tb/tb_encode_out.sv
// Self-checking bench for encode_out: directed streams plus randomized streams
// compared against a bit-queue reference model.
module tb_encode_out;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [12:0] code_data = 13'd0;
  logic [3:0]  code_width = 4'd0;
  logic        code_valid = 1'b0;
  logic        code_last = 1'b0;
  logic        code_ack;
  logic        fo_full = 1'b0;
  logic [63:0] fo_data;
  logic        fo_valid;
  logic        fo_last;
  logic [19:0] enc_cnt;
  logic        enc_done;

  encode_out dut (
    .clk(clk), .rst(rst), .ce(ce),
    .code_data(code_data), .code_width(code_width),
    .code_valid(code_valid), .code_last(code_last), .code_ack(code_ack),
    .fo_full(fo_full), .fo_data(fo_data), .fo_valid(fo_valid),
    .fo_last(fo_last), .enc_cnt(enc_cnt), .enc_done(enc_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_valid_cyc = 0;
  int done_cyc = 0;
  logic [63:0] mon_data[$];
  logic        mon_last[$];
  logic [19:0] mon_cnt[$];
  logic [63:0] exp_data[$];

  logic [12:0] cd [64];
  logic [3:0]  cw [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (fo_valid === 1'b1) begin
      mon_data.push_back(fo_data);
      mon_last.push_back(fo_last);
      mon_cnt.push_back(enc_cnt);
      last_valid_cyc = cyc;
    end
    if (enc_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [63:0] sw(input logic [63:0] w);
    logic [63:0] r;
`ifdef ENCODE_OUT_BSWAP_EN
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[56-8*i +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: serialize all legal code bits into one stream, cut into 64-bit words, zero-pad the tail.
  task automatic build_exp(input int n);
    bit bits[$];
    logic [63:0] w;
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      if (cw[i] >= 4'd1 && cw[i] <= 4'd13) begin
        for (int b = int'(cw[i]) - 1; b >= 0; b--) bits.push_back(cd[i][b]);
      end
    end
    while (bits.size() > 0) begin
      for (int b = 63; b >= 0; b--) w[b] = (bits.size() > 0) ? bits.pop_front() : 1'b0;
      exp_data.push_back(sw(w));
    end
  endtask

  task automatic send(input int n, input bit mark_last, input int stall_at, input int stall_len, input bit rnd);
    for (int i = 0; i < n; i++) begin
      bit taken = 1'b0;
      int guard = 0;
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          code_valid = 1'b1; code_data = cd[i]; code_width = cw[i];
          code_last = mark_last && (i == n - 1); ce = 1'b1; fo_full = 1'b1;
          #1;
          chk("stall_ack", {63'd0, code_ack}, 64'd0);
          chk("stall_valid", {63'd0, fo_valid}, 64'd0);
        end
      end
      while (!taken) begin
        @(negedge clk);
        code_valid = 1'b1; code_data = cd[i]; code_width = cw[i];
        code_last = mark_last && (i == n - 1);
        ce = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        fo_full = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        #1;
        taken = code_ack;
        guard++;
        if (!taken && guard > 200) begin
          chk("ack_timeout", {63'd0, code_ack}, 64'd1);
          taken = 1'b1;
        end
      end
    end
    @(negedge clk);
    code_valid = 1'b0; code_last = 1'b0; ce = 1'b1; fo_full = 1'b0;
  endtask

  task automatic run(input string tag, input int n, input int stall_at, input int stall_len,
                     input bit rnd, input bit timing);
    int done_before = done_cnt;
    int guard = 0;
    mon_data.delete(); mon_last.delete(); mon_cnt.delete();
    build_exp(n);
    send(n, 1'b1, stall_at, stall_len, rnd);
    while (done_cnt == done_before && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk({tag, "_done"}, 64'(done_cnt), 64'(done_before + 1));
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_done_once"}, 64'(done_cnt), 64'(done_before + 1));
    chk({tag, "_cnt_clr"}, 64'(enc_cnt), 64'd0);
    chk({tag, "_nwords"}, 64'(mon_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < mon_data.size() && i < exp_data.size(); i++) begin
      chk({tag, "_data"}, mon_data[i], exp_data[i]);
      chk({tag, "_last"}, {63'd0, mon_last[i]}, {63'd0, (i == exp_data.size() - 1)});
      chk({tag, "_cnt"}, 64'(mon_cnt[i]), 64'(i + 1));
    end
    if (timing && exp_data.size() > 0) begin
      chk({tag, "_done_lat"}, 64'(done_cyc), 64'(last_valid_cyc + 1));
    end
  endtask

  initial begin
    // Reset held with a code offered.
    ce = 1'b1; code_valid = 1'b1; code_width = 4'd8; code_data = 13'h0AA;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data", fo_data, 64'd0);
    chk("rst_valid", {63'd0, fo_valid}, 64'd0);
    chk("rst_last", {63'd0, fo_last}, 64'd0);
    chk("rst_cnt", 64'(enc_cnt), 64'd0);
    chk("rst_done", {63'd0, enc_done}, 64'd0);
    chk("rst_ack", {63'd0, code_ack}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_ack", {63'd0, code_ack}, 64'd1);
    code_valid = 1'b0;

    // Eight 8-bit codes 0x01..0x08.
    for (int i = 0; i < 8; i++) begin cd[i] = 13'(i + 1); cw[i] = 4'd8; end
    run("b8", 8, -1, 0, 1'b0, 1'b1);
    chk("b8_word", mon_data.size() > 0 ? mon_data[0] : 64'd0, sw(64'h0102030405060708));

    // One 9-bit code, flushed.
    cd[0] = 13'h1FF; cw[0] = 4'd9;
    run("b9", 1, -1, 0, 1'b0, 1'b1);
    chk("b9_word", mon_data.size() > 0 ? mon_data[0] : 64'd0, sw(64'hFF80000000000000));

    // Five 13-bit all-ones codes: 65 bits.
    for (int i = 0; i < 5; i++) begin cd[i] = 13'h1FFF; cw[i] = 4'd13; end
    run("b13", 5, -1, 0, 1'b0, 1'b1);
    chk("b13_w0", mon_data.size() > 0 ? mon_data[0] : 64'd0, 64'hFFFFFFFFFFFFFFFF);
    chk("b13_w1", mon_data.size() > 1 ? mon_data[1] : 64'd0, sw(64'h8000000000000000));

    // Back-pressure: 10 stalled cycles after three accepts.
    for (int i = 0; i < 16; i++) begin cd[i] = 13'($urandom); cw[i] = 4'd8; end
    run("bp", 16, 3, 10, 1'b0, 1'b1);

    // Reset in mid-stream drops the partial word.
    for (int i = 0; i < 3; i++) begin cd[i] = 13'h0FF; cw[i] = 4'd8; end
    mon_data.delete(); mon_last.delete(); mon_cnt.delete();
    send(3, 1'b0, -1, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_rst_cnt", 64'(enc_cnt), 64'd0);
    chk("mid_rst_nowords", 64'(mon_data.size()), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin cd[i] = 13'(i + 1); cw[i] = 4'd8; end
    run("after_rst", 8, -1, 0, 1'b0, 1'b1);

    // Randomized streams with random ce, fo_full and occasional illegal widths.
    for (int s = 0; s < 20; s++) begin
      int n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        cd[i] = 13'($urandom);
        if ($urandom_range(0, 9) == 0 && i != n - 1)
          cw[i] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(14, 15));
        else
          cw[i] = 4'($urandom_range(1, 13));
      end
      run("rnd", n, -1, 0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
